// File: rtl/reservation_station_mc_if.sv
// Dispatcher / CDB / issue bundle for reservation_station_mc.
// The master side is the dispatcher and FU control; the slave side is the station.
interface rs_if #(
    parameter int NUM_CDB     = 2,
    parameter int XLEN        = 32,
    parameter int TAG_W       = 4,
    parameter int FUNC_W      = 4,
    parameter int ENTRY_WIDTH = 3
);
    logic                              flush;
    logic                              load;
    logic [FUNC_W-1:0]                 func;
    logic [TAG_W-1:0]                  t1;
    logic [TAG_W-1:0]                  t2;
    logic [TAG_W-1:0]                  dst;
    logic                              ready1;
    logic                              ready2;
    logic [XLEN-1:0]                   v1;
    logic [XLEN-1:0]                   v2;
    logic [NUM_CDB-1:0]                cdb_valid;
    logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag;
    logic [NUM_CDB-1:0][XLEN-1:0]      cdb_value;
    logic                              fu_ready;
    logic                              is_full;
    logic [ENTRY_WIDTH:0]              num_free;
    logic                              issue_valid;
    logic [FUNC_W-1:0]                 func_out;
    logic [XLEN-1:0]                   v1_out;
    logic [XLEN-1:0]                   v2_out;
    logic [TAG_W-1:0]                  dst_out;

    modport master (
        output flush, load, func, t1, t2, dst, ready1, ready2, v1, v2,
               cdb_valid, cdb_tag, cdb_value, fu_ready,
        input  is_full, num_free, issue_valid, func_out, v1_out, v2_out, dst_out
    );

    modport slave (
        input  flush, load, func, t1, t2, dst, ready1, ready2, v1, v2,
               cdb_valid, cdb_tag, cdb_value, fu_ready,
        output is_full, num_free, issue_valid, func_out, v1_out, v2_out, dst_out
    );
endinterface

// File: rtl/reservation_station_mc.sv
// Multi-CDB reservation station for the Tomasulo ALU path.
// Holds renamed instructions until both operands are captured, then issues
// the oldest ready one through a registered output stage.
// Optional feature macro: CDB_BYPASS_EN -- an entry whose last missing operand
// is being broadcast this cycle is already eligible for select, with the
// broadcast value forwarded straight into the output registers.

// Tag comparator against every CDB channel; the lowest-numbered channel wins.
module rs_mc_snoop #(
    parameter int NUM_CDB = 2,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4
) (
    input  logic [TAG_W-1:0]              tag,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB-1:0][XLEN-1:0]  cdb_value,
    output logic                          hit,
    output logic [XLEN-1:0]               value
);
    // Scan high to low so the lowest matching channel is the last writer.
    always_comb begin
        hit   = 1'b0;
        value = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k] == tag) begin
                hit   = 1'b1;
                value = cdb_value[k];
            end
        end
    end
endmodule

module reservation_station_mc #(
    parameter int NUM_ENTRIES = 8,
    parameter int ENTRY_WIDTH = $clog2(NUM_ENTRIES),
    parameter int NUM_CDB     = 2,
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 4,
    parameter int ALU_FUNC_W  = 4
) (
    input logic clk,
    input logic reset,
    rs_if.slave bus
);
    localparam logic [ALU_FUNC_W-1:0]  ALU_ADD = '0;
    localparam logic [ENTRY_WIDTH:0]   CAPACITY = (ENTRY_WIDTH+1)'(NUM_ENTRIES);

    // entry state
    logic [NUM_ENTRIES-1:0]                  e_valid, e_r1, e_r2;
    logic [NUM_ENTRIES-1:0][ALU_FUNC_W-1:0]  e_func;
    logic [NUM_ENTRIES-1:0][ROB_TAG_LEN-1:0] e_t1, e_t2, e_dst;
    logic [NUM_ENTRIES-1:0][XLEN-1:0]        e_v1, e_v2;
    logic [NUM_ENTRIES-1:0][ENTRY_WIDTH-1:0] e_age;

    // snoop results
    logic [NUM_ENTRIES-1:0]                  s1_hit, s2_hit;
    logic [NUM_ENTRIES-1:0][XLEN-1:0]        s1_val, s2_val;
    logic                                    l1_hit, l2_hit;
    logic [XLEN-1:0]                         l1_val, l2_val;

    // derived control
    logic [NUM_ENTRIES-1:0]                  wake1, wake2, rdy;
    logic [NUM_ENTRIES-1:0][XLEN-1:0]        op1, op2;
    logic                                    any_rdy, issue_go, do_load;
    logic [ENTRY_WIDTH-1:0]                  sel, sel_age, slot, new_age;
    logic [ENTRY_WIDTH:0]                    n_valid;

    // output regs
    logic                                    issue_valid;
    logic [ALU_FUNC_W-1:0]                   func_out;
    logic [XLEN-1:0]                         v1_out, v2_out;
    logic [ROB_TAG_LEN-1:0]                  dst_out;

    genvar g;
    generate
        for (g = 0; g < NUM_ENTRIES; g++) begin : g_ent
            rs_mc_snoop #(.NUM_CDB(NUM_CDB), .XLEN(XLEN), .TAG_W(ROB_TAG_LEN)) u_s1 (
                .tag(e_t1[g]), .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag),
                .cdb_value(bus.cdb_value), .hit(s1_hit[g]), .value(s1_val[g]));
            rs_mc_snoop #(.NUM_CDB(NUM_CDB), .XLEN(XLEN), .TAG_W(ROB_TAG_LEN)) u_s2 (
                .tag(e_t2[g]), .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag),
                .cdb_value(bus.cdb_value), .hit(s2_hit[g]), .value(s2_val[g]));
        end
    endgenerate

    rs_mc_snoop #(.NUM_CDB(NUM_CDB), .XLEN(XLEN), .TAG_W(ROB_TAG_LEN)) u_l1 (
        .tag(bus.t1), .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag),
        .cdb_value(bus.cdb_value), .hit(l1_hit), .value(l1_val));
    rs_mc_snoop #(.NUM_CDB(NUM_CDB), .XLEN(XLEN), .TAG_W(ROB_TAG_LEN)) u_l2 (
        .tag(bus.t2), .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag),
        .cdb_value(bus.cdb_value), .hit(l2_hit), .value(l2_val));

    // Per-entry wakeup, readiness and the operand value that would be issued.
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        rdy   = '0;
        op1   = '0;
        op2   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            wake1[i] = e_valid[i] & ~e_r1[i] & s1_hit[i];
            wake2[i] = e_valid[i] & ~e_r2[i] & s2_hit[i];
`ifdef CDB_BYPASS_EN
            rdy[i]   = e_valid[i] & (e_r1[i] | wake1[i]) & (e_r2[i] | wake2[i]);
`else
            rdy[i]   = e_valid[i] & e_r1[i] & e_r2[i];
`endif
            op1[i]   = e_r1[i] ? e_v1[i] : s1_val[i];
            op2[i]   = e_r2[i] ? e_v2[i] : s2_val[i];
        end
    end

    // Oldest-ready select, occupancy count and lowest free slot.
    always_comb begin
        any_rdy = 1'b0;
        sel     = '0;
        sel_age = '0;
        n_valid = '0;
        slot    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (rdy[i] && (!any_rdy || e_age[i] < sel_age)) begin
                any_rdy = 1'b1;
                sel     = ENTRY_WIDTH'(i);
                sel_age = e_age[i];
            end
            n_valid = n_valid + {{ENTRY_WIDTH{1'b0}}, e_valid[i]};
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!e_valid[i]) slot = ENTRY_WIDTH'(i);
        end
        issue_go = bus.fu_ready & any_rdy;
        do_load  = bus.load & ~(&e_valid);
        // Age counts survivors of this cycle's issue, keeping ages dense.
        new_age  = n_valid[ENTRY_WIDTH-1:0] - {{(ENTRY_WIDTH-1){1'b0}}, issue_go};
    end

    assign bus.is_full     = &e_valid;
    assign bus.num_free    = CAPACITY - n_valid;
    assign bus.issue_valid = issue_valid;
    assign bus.func_out    = func_out;
    assign bus.v1_out      = v1_out;
    assign bus.v2_out      = v2_out;
    assign bus.dst_out     = dst_out;

    // Entry update: wakeup, issue departure with age compaction, load, output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid     <= '0;
            issue_valid <= 1'b0;
            func_out    <= ALU_ADD;
            v1_out      <= '0;
            v2_out      <= '0;
            dst_out     <= '0;
        end else if (bus.flush) begin
            e_valid     <= '0;
            issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (wake1[i]) begin
                    e_r1[i] <= 1'b1;
                    e_v1[i] <= s1_val[i];
                end
                if (wake2[i]) begin
                    e_r2[i] <= 1'b1;
                    e_v2[i] <= s2_val[i];
                end
                if (issue_go && sel == ENTRY_WIDTH'(i))
                    e_valid[i] <= 1'b0;
                else if (issue_go && e_valid[i] && e_age[i] > sel_age)
                    e_age[i] <= e_age[i] - 1'b1;
            end
            // The slot is invalid, so nothing above touched it this cycle.
            if (do_load) begin
                e_valid[slot] <= 1'b1;
                e_func[slot]  <= bus.func;
                e_t1[slot]    <= bus.t1;
                e_t2[slot]    <= bus.t2;
                e_dst[slot]   <= bus.dst;
                e_r1[slot]    <= l1_hit | bus.ready1;
                e_r2[slot]    <= l2_hit | bus.ready2;
                e_v1[slot]    <= l1_hit ? l1_val : bus.v1;
                e_v2[slot]    <= l2_hit ? l2_val : bus.v2;
                e_age[slot]   <= new_age;
            end
            issue_valid <= issue_go;
            if (issue_go) begin
                func_out <= e_func[sel];
                v1_out   <= op1[sel];
                v2_out   <= op2[sel];
                dst_out  <= e_dst[sel];
            end
        end
    end
endmodule

// File: tb/tb_reservation_station_mc.sv
// Self-checking bench for reservation_station_mc: table-driven single-insn
// vectors plus hand sequences, with an issue scoreboard checked by a monitor.
module tb_reservation_station_mc;
    localparam int N  = 8;
    localparam int EW = 3;
    localparam int NC = 2;
    localparam int XL = 32;
    localparam int TW = 4;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rs_if #(.NUM_CDB(NC), .XLEN(XL), .TAG_W(TW), .FUNC_W(FW), .ENTRY_WIDTH(EW)) bus();

    reservation_station_mc #(
        .NUM_ENTRIES(N), .ENTRY_WIDTH(EW), .NUM_CDB(NC),
        .XLEN(XL), .ROB_TAG_LEN(TW), .ALU_FUNC_W(FW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [FW-1:0] func;
        logic [XL-1:0] v1;
        logic [XL-1:0] v2;
        logic [TW-1:0] dst;
    } iss_t;

    typedef struct {
        logic [FW-1:0] func;
        logic [TW-1:0] t1, t2, dst;
        logic          r1, r2;
        logic [XL-1:0] v1, v2;
        logic          cv;
        logic [TW-1:0] ctag;
        logic [XL-1:0] cval;
        logic [XL-1:0] e1, e2;
    } vec_t;

    iss_t exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.load      = 1'b0;
        bus.flush     = 1'b0;
        bus.func      = '0;
        bus.t1        = '0;
        bus.t2        = '0;
        bus.dst       = '0;
        bus.ready1    = 1'b0;
        bus.ready2    = 1'b0;
        bus.v1        = '0;
        bus.v2        = '0;
        bus.cdb_valid = '0;
        bus.cdb_tag   = '0;
        bus.cdb_value = '0;
    endtask

    task automatic ld(input logic [FW-1:0] f, input logic [TW-1:0] a, input logic ra,
                      input logic [XL-1:0] va, input logic [TW-1:0] b, input logic rb,
                      input logic [XL-1:0] vb, input logic [TW-1:0] d);
        bus.load = 1'b1; bus.func = f;
        bus.t1 = a; bus.ready1 = ra; bus.v1 = va;
        bus.t2 = b; bus.ready2 = rb; bus.v2 = vb;
        bus.dst = d;
    endtask

    task automatic bc(input int ch, input logic [TW-1:0] tg, input logic [XL-1:0] val);
        bus.cdb_valid[ch] = 1'b1;
        bus.cdb_tag[ch]   = tg;
        bus.cdb_value[ch] = val;
    endtask

    task automatic expect_iss(input logic [FW-1:0] f, input logic [XL-1:0] a,
                              input logic [XL-1:0] b, input logic [TW-1:0] d);
        iss_t e;
        e.func = f; e.v1 = a; e.v2 = b; e.dst = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int maxc);
        int c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            tick();
            c++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d issues still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Every issue must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.issue_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_issue: got dst %0h expected no issue", bus.dst_out);
            end else begin
                iss_t e;
                e = exp_q.pop_front();
                check("iss_func", 32'(bus.func_out), 32'(e.func));
                check("iss_v1",   bus.v1_out, e.v1);
                check("iss_v2",   bus.v2_out, e.v2);
                check("iss_dst",  32'(bus.dst_out), 32'(e.dst));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{4'd0, 4'd3, 4'd4, 4'd9, 1'b1, 1'b1, 32'd5,    32'd7,    1'b0, 4'd0, 32'd0,    32'd5,    32'd7};
        vecs[1] = '{4'd2, 4'd5, 4'd0, 4'd4, 1'b0, 1'b1, 32'd0,    32'd3,    1'b1, 4'd5, 32'hAA,   32'hAA,   32'd3};
        vecs[2] = '{4'd3, 4'd1, 4'd5, 4'd5, 1'b1, 1'b1, 32'h10,   32'h20,   1'b1, 4'd5, 32'hBB,   32'h10,   32'hBB};
        vecs[3] = '{4'd1, 4'd2, 4'd3, 4'd6, 1'b1, 1'b1, 32'h30,   32'h40,   1'b1, 4'd6, 32'd1,    32'h30,   32'h40};
        vecs[4] = '{4'd5, 4'd2, 4'd2, 4'd7, 1'b0, 1'b0, 32'd0,    32'd0,    1'b1, 4'd2, 32'h77,   32'h77,   32'h77};

        idle();
        bus.fu_ready = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("rst_func_out",    32'(bus.func_out), 32'd0);
        check("rst_v1_out",      bus.v1_out, 32'd0);
        check("rst_v2_out",      bus.v2_out, 32'd0);
        check("rst_dst_out",     32'(bus.dst_out), 32'd0);
        check("rst_num_free",    32'(bus.num_free), 32'd8);
        check("rst_is_full",     32'(bus.is_full), 32'd0);

        // Single insns, incl. CDB capture at load: issue two edges after load.
        for (int i = 0; i < 5; i++) begin
            ld(vecs[i].func, vecs[i].t1, vecs[i].r1, vecs[i].v1,
               vecs[i].t2, vecs[i].r2, vecs[i].v2, vecs[i].dst);
            if (vecs[i].cv) bc(1, vecs[i].ctag, vecs[i].cval);
            bus.fu_ready = 1'b1;
            expect_iss(vecs[i].func, vecs[i].e1, vecs[i].e2, vecs[i].dst);
            tick();
            idle();
            check("vec_lat_load", 32'(bus.issue_valid), 32'd0);
            check("vec_free_load", 32'(bus.num_free), 32'd7);
            tick();
            check("vec_lat_issue", 32'(bus.issue_valid), 32'd1);
            tick();
            check("vec_free_after", 32'(bus.num_free), 32'd8);
        end

        // Fill with 8 waiting insns, drop extra loads, wake in reverse, issue in load order.
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld(4'd1, 4'(i + 1), 1'b0, 32'd0, 4'd0, 1'b1, 32'(i), 4'(i + 1));
            tick();
            idle();
            check("fill_num_free", 32'(bus.num_free), 32'(7 - i));
        end
        check("full_is_full", 32'(bus.is_full), 32'd1);
        ld(4'd2, 4'd1, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, 4'd15);
        tick();
        idle();
        check("drop_num_free", 32'(bus.num_free), 32'd0);
        for (int p = 0; p < 4; p++) begin
            bc(0, 4'(8 - 2 * p), 32'(108 - 2 * p));
            bc(1, 4'(7 - 2 * p), 32'(107 - 2 * p));
            tick();
            idle();
        end
        check("woken_still_full", 32'(bus.is_full), 32'd1);
        for (int i = 0; i < 8; i++) expect_iss(4'd1, 32'(101 + i), 32'(i), 4'(i + 1));
        // Issue in this cycle must not make room for a load.
        bus.fu_ready = 1'b1;
        ld(4'd3, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd14);
        tick();
        idle();
        wait_drain(20);
        tick(); tick();
        check("drain_num_free", 32'(bus.num_free), 32'd8);

        // Younger ready entry passes older waiting one; then wakeup latency.
        bus.fu_ready = 1'b0;
        ld(4'd4, 4'd0, 1'b1, 32'h11, 4'd6, 1'b0, 32'd0, 4'd1);
        tick();
        ld(4'd6, 4'd0, 1'b1, 32'h22, 4'd0, 1'b1, 32'h33, 4'd2);
        tick();
        idle();
        expect_iss(4'd6, 32'h22, 32'h33, 4'd2);
        bus.fu_ready = 1'b1;
        tick();
        check("young_issued", 32'(bus.issue_valid), 32'd1);
        expect_iss(4'd4, 32'h11, 32'h55, 4'd1);
        bc(0, 4'd6, 32'h55);
        tick();
        idle();
`ifdef CDB_BYPASS_EN
        check("bypass_issue", 32'(bus.issue_valid), 32'd1);
`else
        check("capture_wait", 32'(bus.issue_valid), 32'd0);
        tick();
        check("capture_issue", 32'(bus.issue_valid), 32'd1);
`endif
        wait_drain(4);

        // Same tag on both channels: channel 0 value wins.
        bus.fu_ready = 1'b0;
        ld(4'd7, 4'd7, 1'b0, 32'd0, 4'd0, 1'b1, 32'h5, 4'd3);
        tick();
        idle();
        bc(0, 4'd7, 32'd1);
        bc(1, 4'd7, 32'd2);
        tick();
        idle();
        expect_iss(4'd7, 32'd1, 32'h5, 4'd3);
        bus.fu_ready = 1'b1;
        wait_drain(4);

        // Flush overrides load and issue in the same cycle; data outputs hold.
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld(4'd1, 4'(10 + i), 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, 4'(10 + i));
            tick();
        end
        ld(4'd1, 4'd0, 1'b1, 32'h9, 4'd0, 1'b1, 32'h9, 4'd8);
        tick();
        idle();
        check("pre_flush_free", 32'(bus.num_free), 32'd4);
        ld(4'd2, 4'd0, 1'b1, 32'h3, 4'd0, 1'b1, 32'h3, 4'd9);
        bus.flush = 1'b1;
        bus.fu_ready = 1'b1;
        tick();
        idle();
        check("flush_num_free", 32'(bus.num_free), 32'd8);
        check("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("flush_hold_v1", bus.v1_out, 32'd1);
        check("flush_hold_dst", 32'(bus.dst_out), 32'd3);
        bc(0, 4'd10, 32'd0);
        bc(1, 4'd11, 32'd0);
        tick();
        idle();
        bc(0, 4'd12, 32'd0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            check("flush_no_issue", 32'(bus.issue_valid), 32'd0);
            tick();
        end

        // Reset mid-operation discards the pending issue and clears outputs.
        bus.fu_ready = 1'b0;
        ld(4'd3, 4'd0, 1'b1, 32'h99, 4'd0, 1'b1, 32'h98, 4'd13);
        tick();
        idle();
        reset = 1'b1;
        bus.fu_ready = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("mid_rst_num_free", 32'(bus.num_free), 32'd8);
        check("mid_rst_func_out", 32'(bus.func_out), 32'd0);
        check("mid_rst_v1_out", bus.v1_out, 32'd0);
        check("mid_rst_dst_out", 32'(bus.dst_out), 32'd0);
        tick(); tick(); tick();
        check("mid_rst_no_issue", 32'(bus.issue_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
